// File: rtl/santim_prog.sv
// Programmable sanity timer: counts host inactivity against a selectable timeout and
// emits a fixed-length BDCOK-negate pulse on expiry or on an explicit force request.
module santim_prog #(
    parameter int unsigned TICK_DIV     = 625000,
    parameter int unsigned PULSE_CYCLES = 10
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic [2:0] sel_i,
    input  logic       kick_i,
    input  logic       force_i,
    output logic       out_o,
    output logic       expired_o,
    output logic       active_o
);

    localparam int unsigned PresW  = $clog2(TICK_DIV);
    localparam int unsigned PulseW = $clog2(PULSE_CYCLES + 1);
    localparam logic [PresW-1:0]  PresMax  = PresW'(TICK_DIV - 1);
    localparam logic [PulseW-1:0] PulseMax = PulseW'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StArmed, StFire} state_e;

    state_e              state_q, state_d;
    logic [PresW-1:0]    pres_q, pres_d;
    logic [13:0]         tick_q, tick_d;
    logic [13:0]         limit_q, limit_d;
    logic [PulseW-1:0]   pulse_q, pulse_d;
    logic                out_q, out_d;
    logic                expired_q, expired_d;
    logic                active_q, active_d;
    logic [13:0]         n_sel;
    logic                wrap;

    always_comb begin
        unique case (sel_i)
            3'd0:    n_sel = 14'd1;
            3'd1:    n_sel = 14'd4;
            3'd2:    n_sel = 14'd16;
            3'd3:    n_sel = 14'd64;
            3'd4:    n_sel = 14'd240;
            3'd5:    n_sel = 14'd960;
            3'd6:    n_sel = 14'd3840;
            default: n_sel = 14'd15360;
        endcase
    end

    assign wrap = (pres_q == PresMax);

    always_comb begin
        state_d   = state_q;
        pres_d    = pres_q;
        tick_d    = tick_q;
        limit_d   = limit_q;
        pulse_d   = pulse_q;
        expired_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (force_i) begin
                    state_d = StFire;
                    pulse_d = '0;
                end else if (enable_i) begin
                    state_d = StArmed;
                    pres_d  = '0;
                    tick_d  = '0;
                    limit_d = n_sel;
                end
            end
            StArmed: begin
                // Priority: force > disable > kick > expiry.
                if (force_i) begin
                    state_d = StFire;
                    pulse_d = '0;
                    pres_d  = '0;
                    tick_d  = '0;
                end else if (!enable_i) begin
                    state_d = StIdle;
                    pres_d  = '0;
                    tick_d  = '0;
                end else if (kick_i) begin
                    pres_d  = '0;
                    tick_d  = '0;
                    limit_d = n_sel;
                end else if (wrap) begin
                    pres_d = '0;
                    if (tick_q == limit_q - 14'd1) begin
                        state_d   = StFire;
                        pulse_d   = '0;
                        tick_d    = '0;
                        expired_d = 1'b1;
                    end else begin
                        tick_d = tick_q + 14'd1;
                    end
                end else begin
                    pres_d = pres_q + PresW'(1);
                end
            end
            StFire: begin
                // The pulse always runs to completion; only enable_i at its end matters.
                if (pulse_q == PulseMax) begin
                    pulse_d = '0;
                    if (enable_i) begin
                        state_d = StArmed;
                        pres_d  = '0;
                        tick_d  = '0;
                        limit_d = n_sel;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    pulse_d = pulse_q + PulseW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        out_d    = (state_d == StFire);
        active_d = (state_d == StArmed);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            pres_q    <= '0;
            tick_q    <= '0;
            limit_q   <= '0;
            pulse_q   <= '0;
            out_q     <= 1'b0;
            expired_q <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pres_q    <= pres_d;
            tick_q    <= tick_d;
            limit_q   <= limit_d;
            pulse_q   <= pulse_d;
            out_q     <= out_d;
            expired_q <= expired_d;
            active_q  <= active_d;
        end
    end

    assign out_o     = out_q;
    assign expired_o = expired_q;
    assign active_o  = active_q;

endmodule

// File: doc/santim_prog.md
# santim_prog

Programmable sanity timer with BDCOK pulse generation for the DELQA-compatible Ethernet controller. Once armed, it counts host-inactivity time against one of eight selectable timeouts (1/4 s to 64 min, per the DEQNA/DELQA sanity timer set). On expiry, or on an explicit force request, it emits an active-1 BDCOK-negate pulse of parametrised length. It replaces the fixed single-shot BDCOK generator and sits between the CSR/setup-packet logic, which drives enable, select and kick, and the Q-bus BDCOK driver.

## Interface
- TICK_DIV, 625000: clock cycles per base tick. 1/4 s at 2.5 MHz. Minimum 2.
- PULSE_CYCLES, 10: out_o high time in cycles. About 4 µs at 2.5 MHz. Minimum 1.
- clock_i  in  1  single clock (2.5 MHz nominal).
- reset_i  in  1  reset, asynchronous, active-high.
- enable_i  in  1  level; 1 = sanity timer enabled.
- sel_i  in  3  timeout select. Sampled only at arm and at each accepted kick.
- kick_i  in  1  one-cycle strobe; restarts the timeout (host activity).
- force_i  in  1  one-cycle strobe; requests an immediate BDCOK pulse.
- out_o  out  1  BDCOK-negate pulse, active 1.
- expired_o  out  1  one-cycle strobe on timeout expiry. Not asserted for force.
- active_o  out  1  1 while in ARMED.

## Operation
- Timeout table, N ticks per sel_i value: 0→1, 1→4, 2→16, 3→64, 4→240, 5→960, 6→3840, 7→15360.
- Tick counter is 14 bits. Prescaler width is $clog2(TICK_DIV). Pulse counter width is $clog2(PULSE_CYCLES+1).
- Latched limit register N_q holds N for the current run.
- All outputs are registered. Reset value of every output and counter is 0; state resets to IDLE.
- States:
  - IDLE: enable_i=1 → ARMED. Arming clears prescaler and tick count and latches N_q from sel_i. force_i → FIRE.
  - ARMED: prescaler counts 0..TICK_DIV-1 and wraps. Each wrap increments the tick count. A wrap with tick count = N_q-1 is expiry: go to FIRE and pulse expired_o.
  - ARMED exits and restarts:
    - enable_i=0 → IDLE; counters cleared.
    - kick_i → stay ARMED; clear prescaler and tick count; relatch N_q from sel_i.
    - force_i → FIRE.
  - FIRE: out_o=1 for exactly PULSE_CYCLES cycles. When the count completes:
    - enable_i=1 → ARMED (fresh arm: counters cleared, N_q relatched).
    - otherwise → IDLE.
  - FIRE ignores kick_i, force_i and enable_i changes; the pulse always runs to completion.
- Simultaneous events in ARMED, by priority: force_i > enable_i=0 > kick_i > expiry.
  - A kick on the expiry cycle suppresses the expiry (no FIRE, no expired_o).
- sel_i changes while ARMED take effect only at the next kick or re-arm.
- Asynchronous reset at any time, including mid-count or mid-pulse, forces IDLE and drops out_o to 0 immediately.

## Timing
- Arm edge E0 is the clock edge where IDLE samples enable_i=1. active_o=1 from E0.
- Expiry edge is E0 + N_q·TICK_DIV. At that edge out_o and expired_o go to 1 and active_o goes to 0.
- expired_o falls one cycle later. out_o falls PULSE_CYCLES cycles after it rose.
- A kick at edge K moves the next expiry to K + N_q·TICK_DIV.
- force_i sampled at edge F → out_o=1 from edge F. No expired_o.
- Auto re-arm: if enable_i=1 at pulse end, ARMED begins on the edge where out_o falls. The next expiry is N_q·TICK_DIV cycles later.

## Test plan
Benches use TICK_DIV=4 and PULSE_CYCLES=10.
- Reset, then enable_i=1 with sel_i=0 → active_o rises at E0. out_o rises at E0+4 and stays high for 10 cycles. expired_o is high for 1 cycle at E0+4.
- sel_i=1, kick_i every 12 cycles for 100 cycles → out_o never asserts. Stop kicking at K → out_o rises at K+16.
- Expiry path with sel_i=2: kick_i on the exact expiry edge (E0+64) → no pulse. Next expiry at E0+128.
- force_i in IDLE → 10-cycle out_o, expired_o stays 0, return to IDLE. Then, with ARMED and sel_i=1, force_i and kick_i on the same cycle → pulse starts that edge.
- enable_i held at 1 with sel_i=0 → periodic pulses. Rising edges are 14 cycles apart (4 counting + 10 pulse).
- reset_i asserted mid-pulse and mid-count → out_o and active_o drop asynchronously to 0. After release, the block stays IDLE until enable_i is sampled high.
